// File: rtl/if_fetch_if.sv
// Byte-serial read bus between the instruction-fetch stage and the memory controller.
// The fetch stage is the master: it holds mem_req/mem_addr until each byte is acked.
interface if_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;

   modport master (output mem_req, mem_addr, input mem_ack, mem_data);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped one-word-per-line I-cache in front of a
// byte-serial memory bus, delivering inst/inst_pc/inst_valid to the IF/ID boundary.
module if_fetch #(
   parameter int ICACHE_LINES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        jump_flag,
   input  logic [4:0]  stall_signal,
   output logic        if_stall_req,
   if_fetch_if.master  mem,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid
);
   localparam int INDEX_BITS = $clog2(ICACHE_LINES);
   localparam int TAG_BITS   = 30 - INDEX_BITS;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t                  state;
   logic [ICACHE_LINES-1:0] line_valid;
   logic [TAG_BITS-1:0]     line_tag  [ICACHE_LINES];
   logic [31:0]             line_data [ICACHE_LINES];

   logic [31:0]           fetch_pc;
   logic [1:0]            byte_cnt;
   logic [23:0]           byte_buf;
   logic                  req;
   logic [INDEX_BITS-1:0] index;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic                  hold_out;
   logic                  fill_done;
   logic                  unused_inputs;

   assign index      = pc[INDEX_BITS+1:2];
   assign tag        = pc[31:INDEX_BITS+2];
   assign hit        = (state == IDLE) && line_valid[index] && (line_tag[index] == tag);
   assign hold_out   = stall_signal[1];
   assign fill_index = fetch_pc[INDEX_BITS+1:2];
   // The 4th ack completes the line even when a jump lands on the same edge.
   assign fill_done  = (state == FETCH) && mem.mem_ack && (byte_cnt == 2'd3);

   // hit is only ever true in IDLE, so this also covers the whole of FETCH.
   assign if_stall_req = !hit;
   assign mem.mem_req  = req;
   assign mem.mem_addr = fetch_pc + {30'd0, byte_cnt};

   assign unused_inputs = ^{pc[1:0], stall_signal[4:2], stall_signal[0]};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         line_valid <= '0;
         fetch_pc   <= '0;
         byte_cnt   <= '0;
         byte_buf   <= '0;
         req        <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         if (fill_done) begin
            line_valid[fill_index] <= 1'b1;
         end

         if (jump_flag) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            req        <= 1'b0;
            inst_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!hit && !hold_out) begin
                     fetch_pc <= {pc[31:2], 2'b00};
                     byte_cnt <= '0;
                     req      <= 1'b1;
                     state    <= FETCH;
                  end
               end
               FETCH: begin
                  if (mem.mem_ack) begin
                     case (byte_cnt)
                        2'd0:    byte_buf[7:0]   <= mem.mem_data;
                        2'd1:    byte_buf[15:8]  <= mem.mem_data;
                        2'd2:    byte_buf[23:16] <= mem.mem_data;
                        default: ;
                     endcase
                     // Wraps to 0 on the last byte, leaving mem_addr back at fetch_pc.
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        req   <= 1'b0;
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase

            if (!hold_out) begin
               inst_valid <= hit;
               if (hit) begin
                  inst    <= line_data[index];
                  inst_pc <= pc;
               end
            end
         end
      end
   end

   // NOTE: tag/data arrays are deliberately not reset; line_valid alone
   // qualifies them, which keeps the arrays mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         line_tag[fill_index]  <= fetch_pc[31:INDEX_BITS+2];
         line_data[fill_index] <= {mem.mem_data, byte_buf};
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed cycle table, async-reset sequence,
// then randomized traffic against a transaction-level cache/memory model.
module tb_if_fetch;
   localparam int LINES = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        jump_flag;
   logic [4:0]  stall_signal;
   logic        if_stall_req;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;

   if_fetch_if bus();

   if_fetch #(.ICACHE_LINES(LINES)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .jump_flag    (jump_flag),
      .stall_signal (stall_signal),
      .if_stall_req (if_stall_req),
      .mem          (bus),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] p, input logic j, input logic [4:0] s,
                        input logic a, input logic [7:0] d);
      pc           = p;
      jump_flag    = j;
      stall_signal = s;
      bus.mem_ack  = a;
      bus.mem_data = d;
      #1;
   endtask

   // One row per clock: inputs, pre-edge expectations, post-edge expectations.
   typedef struct {
      logic [31:0] pc;
      logic        jump;
      logic [4:0]  stall;
      logic        ack;
      logic [7:0]  data;
      logic        e_sreq;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] p, input logic j, input logic [4:0] s, input logic a,
                      input logic [7:0] d, input logic esr, input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      vec_t r;
      r.pc = p; r.jump = j; r.stall = s; r.ack = a; r.data = d;
      r.e_sreq = esr; r.e_req = er; r.e_addr = ea;
      r.e_valid = ev; r.e_inst = ei; r.e_pc = ep;
      vecs.push_back(r);
   endtask

   // Reference model: lines keyed by full word address, pending fetch as a byte-address queue.
   logic [7:0]  img [4096];
   bit          m_valid [LINES];
   logic [31:0] m_line  [LINES];
   logic [31:0] m_word  [LINES];
   logic [31:0] pend [$];
   logic [31:0] m_fetch_pc;
   logic [31:0] pool [16];
   logic        exp_valid;
   logic [31:0] exp_inst;
   logic [31:0] exp_pc;

   function automatic logic [31:0] img_word(input logic [31:0] a);
      int b;
      b = int'(a[11:0]);
      return {img[b+3], img[b+2], img[b+1], img[b]};
   endfunction

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b1;
      drive(32'h0, 1'b0, 5'b0, 1'b0, 8'h00);
      tick();
      tick();
      check("reset mem_req",    32'(bus.mem_req), 32'd0);
      check("reset mem_addr",   bus.mem_addr,     32'd0);
      check("reset inst",       inst,             32'd0);
      check("reset inst_pc",    inst_pc,          32'd0);
      check("reset inst_valid", 32'(inst_valid),  32'd0);
      rst = 1'b0;

      // ---------------- directed table ----------------
      // cold miss at 0x0
      add(32'h0,   0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h13, 1, 1, 32'h0,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h05, 1, 1, 32'h1,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h00, 1, 1, 32'h2,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h00, 1, 1, 32'h3,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h00000513, 32'h0);
      // jump clears output, then a plain hit
      add(32'h0,   1, 5'b0, 0, 8'h00, 0, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h00000513, 32'h0);
      // fill 0x8
      add(32'h8,   0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h8,   0, 5'b0, 1, 8'h93, 1, 1, 32'h8,   0, 32'h0, 32'h0);
      add(32'h8,   0, 5'b0, 1, 8'h00, 1, 1, 32'h9,   0, 32'h0, 32'h0);
      add(32'h8,   0, 5'b0, 1, 8'h10, 1, 1, 32'hA,   0, 32'h0, 32'h0);
      add(32'h8,   0, 5'b0, 1, 8'h00, 1, 1, 32'hB,   0, 32'h0, 32'h0);
      add(32'h8,   0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h00100093, 32'h8);
      // output hold for 3 cycles while 0x40 misses: no fetch starts
      add(32'h40,  0, 5'b00011, 0, 8'h00, 1, 0, 32'h0, 1, 32'h00100093, 32'h8);
      add(32'h40,  0, 5'b00011, 0, 8'h00, 1, 0, 32'h0, 1, 32'h00100093, 32'h8);
      add(32'h40,  0, 5'b00011, 0, 8'h00, 1, 0, 32'h0, 1, 32'h00100093, 32'h8);
      // release: fetch 0x40, abort with a jump after the 2nd ack
      add(32'h40,  0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 1, 8'hB7, 1, 1, 32'h40,  0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 1, 8'h02, 1, 1, 32'h41,  0, 32'h0, 32'h0);
      add(32'h40,  1, 5'b0, 0, 8'h00, 1, 1, 32'h42,  0, 32'h0, 32'h0);
      // 0x40 misses again with fresh requests; jump on the 4th ack still fills
      add(32'h40,  0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 1, 8'h37, 1, 1, 32'h40,  0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 1, 8'h12, 1, 1, 32'h41,  0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 1, 8'h00, 1, 1, 32'h42,  0, 32'h0, 32'h0);
      add(32'h40,  1, 5'b0, 1, 8'h00, 1, 1, 32'h43,  0, 32'h0, 32'h0);
      add(32'h40,  0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h00001237, 32'h40);
      // conflict: 0x100 evicts 0x000 from line 0
      add(32'h100, 0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h100, 0, 5'b0, 1, 8'h11, 1, 1, 32'h100, 0, 32'h0, 32'h0);
      add(32'h100, 0, 5'b0, 1, 8'h22, 1, 1, 32'h101, 0, 32'h0, 32'h0);
      add(32'h100, 0, 5'b0, 1, 8'h33, 1, 1, 32'h102, 0, 32'h0, 32'h0);
      add(32'h100, 0, 5'b0, 1, 8'h44, 1, 1, 32'h103, 0, 32'h0, 32'h0);
      add(32'h100, 0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h44332211, 32'h100);
      add(32'h0,   0, 5'b0, 0, 8'h00, 1, 0, 32'h0,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h13, 1, 1, 32'h0,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h05, 1, 1, 32'h1,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h00, 1, 1, 32'h2,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 1, 8'h00, 1, 1, 32'h3,   0, 32'h0, 32'h0);
      add(32'h0,   0, 5'b0, 0, 8'h00, 0, 0, 32'h0,   1, 32'h00000513, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].pc, vecs[i].jump, vecs[i].stall, vecs[i].ack, vecs[i].data);
         check($sformatf("v%0d if_stall_req", i), 32'(if_stall_req), 32'(vecs[i].e_sreq));
         check($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req) check($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
         tick();
         check($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d inst", i), inst, vecs[i].e_inst);
            check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_pc);
         end
      end

      // ---------------- async reset mid-fetch ----------------
      drive(32'h80, 1'b0, 5'b0, 1'b0, 8'h00);
      check("areset pre stall_req", 32'(if_stall_req), 32'd1);
      tick();
      drive(32'h80, 1'b0, 5'b0, 1'b1, 8'hAA);
      check("areset first addr", bus.mem_addr, 32'h80);
      tick();
      drive(32'h80, 1'b0, 5'b0, 1'b0, 8'h00);
      check("areset req before", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      #1;
      check("areset mem_req",    32'(bus.mem_req), 32'd0);
      check("areset inst_valid", 32'(inst_valid),  32'd0);
      check("areset inst",       inst,             32'd0);
      tick();
      rst = 1'b0;
      drive(32'h0, 1'b0, 5'b0, 1'b0, 8'h00);
      check("areset pc0 misses", 32'(if_stall_req), 32'd1);
      check("areset pc0 no req", 32'(bus.mem_req),  32'd0);
      tick();
      check("areset pc0 bubble", 32'(inst_valid), 32'd0);

      // ---------------- randomized traffic vs model ----------------
      for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         pool[i]     = $urandom & 32'hFFFF_FFFC;
         pool[i + 8] = pool[i] ^ 32'h0000_0100;
      end
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      pend.delete();
      exp_valid = 1'b0;
      exp_inst  = '0;
      exp_pc    = '0;
      rst = 1'b1;
      drive(32'h0, 1'b0, 5'b0, 1'b0, 8'h00);
      tick();
      rst = 1'b0;

      begin
         logic [31:0] cur_pc;
         cur_pc = pool[0];
         for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       j, a, fetching, hit, sreq, complete;
            logic [4:0] s;
            logic [7:0] d;
            int         idx;
            j = ($urandom_range(0, 11) == 0);
            s = 5'($urandom_range(0, 31));
            s[1] = ($urandom_range(0, 5) == 0);
            if (s[1]) s[0] = 1'b1;
            fetching = (pend.size() != 0);
            idx  = int'(cur_pc[7:2]);
            hit  = !fetching && m_valid[idx] && (m_line[idx] == cur_pc);
            sreq = fetching || !hit;
            a = fetching ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            d = fetching ? img[int'(pend[0][11:0])] : 8'($urandom);

            drive(cur_pc, j, s, a, d);
            check("rnd if_stall_req", 32'(if_stall_req), 32'(sreq));
            check("rnd mem_req", 32'(bus.mem_req), 32'(fetching));
            if (fetching) check("rnd mem_addr", bus.mem_addr, pend[0]);

            complete = fetching && a && (pend.size() == 1);
            if (fetching && a) void'(pend.pop_front());
            if (complete) begin
               m_valid[int'(m_fetch_pc[7:2])] = 1'b1;
               m_line[int'(m_fetch_pc[7:2])]  = m_fetch_pc;
               m_word[int'(m_fetch_pc[7:2])]  = img_word(m_fetch_pc);
            end
            if (j) begin
               pend.delete();
               exp_valid = 1'b0;
            end else begin
               if (!fetching && !hit && !s[1]) begin
                  m_fetch_pc = cur_pc;
                  for (int k = 0; k < 4; k++) pend.push_back(cur_pc + 32'(k));
               end
               if (!s[1]) begin
                  exp_valid = hit;
                  if (hit) begin
                     exp_inst = m_word[idx];
                     exp_pc   = cur_pc;
                  end
               end
            end

            tick();
            check("rnd inst_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
               check("rnd inst", inst, exp_inst);
               check("rnd inst_pc", inst_pc, exp_pc);
            end
            if (j || !(sreq || s[0])) cur_pc = pool[$urandom_range(0, 15)];
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage directly downstream of the PC register. Takes the current word-aligned pc and looks it up in a small direct-mapped instruction cache. On a miss it fetches the 32-bit instruction byte-serially from the memory controller and fills the cache. It delivers inst/inst_pc/inst_valid to the IF/ID boundary and raises a stall request while a fetch is outstanding.

Parameters:
ICACHE_LINES, 64, number of one-word cache lines (power of two); INDEX_BITS = log2(ICACHE_LINES)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc  in  32  fetch address from PC register; bits [1:0] must be 0
jump_flag  in  1  branch/jump redirect; flushes the in-flight fetch and the output
stall_signal  in  5  pipeline stall vector; bit1 = hold IF/ID output; controller guarantees bit1 implies bit0
if_stall_req  out  1  to stall controller: fetch not complete, PC must hold
mem_req  out  1  byte read request to memory controller
mem_addr  out  32  byte address of current request
mem_ack  in  1  one-cycle pulse: mem_data valid for current mem_addr
mem_data  in  8  returned byte
inst  out  32  fetched instruction
inst_pc  out  32  pc of inst
inst_valid  out  1  inst/inst_pc valid this cycle

Behaviour:
- Reset (async): state IDLE; all cache valid bits 0; byte_cnt 0; mem_req 0; mem_addr 0; inst 0; inst_pc 0; inst_valid 0.
- Cache: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. Hit = valid[index] && tag match. Lookup is combinational on pc in IDLE.
- States: IDLE, FETCH.
- IDLE, hit: if_stall_req 0. Output updates at the next edge (see output rule). Latency is 1 cycle.
- IDLE, miss, no jump, stall_signal[1]=0:
  - if_stall_req 1.
  - Latch fetch_pc = {pc[31:2],2'b00}; byte_cnt 0; mem_req 1; mem_addr = fetch_pc; go to FETCH.
- IDLE, miss, stall_signal[1]=1: do not start the fetch. Wait in IDLE, if_stall_req 1.
- FETCH:
  - if_stall_req 1. mem_req stays 1, mem_addr = fetch_pc + byte_cnt.
  - On mem_ack, mem_data goes to byte lane byte_cnt (little-endian: byte 0 → [7:0]) and byte_cnt increments.
  - On the 4th ack: write the assembled word, tag and valid into the line; mem_req 0; state IDLE.
  - The next IDLE cycle hits and produces the output. No duplicate issue.
- FETCH ignores pc changes; pc is held by the stall.
- mem_ack while mem_req=0 is ignored.
- Miss timing with single-cycle acks: pc presented in cycle 0; acks in cycles 1-4; hit in cycle 5; inst_valid=1 after the cycle-5 edge.
- jump_flag has highest priority after reset. At the edge it is sampled:
  - state IDLE, byte_cnt 0, mem_req 0; inst_valid 0, regardless of stall_signal.
  - Partial line data is discarded; the cache is not written.
  - Exception: if jump coincides with the 4th ack, the line is written, since its data is complete and correct for fetch_pc.
- Output rule, each edge without jump:
  - stall_signal[1]=1: hold inst, inst_pc, inst_valid.
  - Otherwise, IDLE hit: inst_valid 1, inst = line data, inst_pc = pc.
  - Otherwise: inst_valid 0 (bubble). inst and inst_pc may hold stale values.
- Conflicting addresses (same index, different tag) evict the previous line. No other replacement policy.
- Reset asserted mid-FETCH aborts immediately: mem_req falls asynchronously and the cache is invalidated.

Test Plan:
- Cold miss: reset, pc=0x0. Memory acks bytes 0x13,0x05,0x00,0x00 in cycles 1-4 → mem_addr 0x0,0x1,0x2,0x3; if_stall_req 1 in cycles 0-4; inst=0x00000513, inst_pc=0x0, inst_valid=1 after cycle-5 edge.
- Hit: after the cold miss, jump to 0x0, then present pc=0x0 → inst_valid=1 with 0x00000513 one cycle later; mem_req never asserted.
- Jump abort: miss at pc=0x40, jump_flag after 2nd ack → mem_req 0 next cycle, inst_valid 0. Later pc=0x40 misses again, with 4 fresh requests from 0x40.
- Output hold: hit producing inst_pc=0x8, then stall_signal=5'b00011 for 3 cycles → inst, inst_pc, inst_valid constant. No fetch starts on a concurrent miss.
- Conflict eviction (ICACHE_LINES=64): fill 0x000, then 0x100 (same index 0) → re-presenting 0x000 misses and refetches from mem_addr 0x000.
- Async reset mid-FETCH after 1 ack → mem_req 0 and inst_valid 0 without a clock edge; subsequent pc=0x0 misses.
